// File: rtl/jtdd_snd_mix.sv
// Multi-channel sound mixer: snapshots CH signed channels on cen, accumulates
// gain-weighted samples with one multiplier per clock, then shifts and saturates.
module jtdd_snd_mix #(
  parameter int CH    = 4,
  parameter int WIN   = 16,
  parameter int WOUT  = 16,
  parameter int GAINW = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cen,
  input  logic [CH*WIN-1:0]       ch_in,
  input  logic [CH*GAINW-1:0]     gain,
  input  logic [CH-1:0]           mute,
  input  logic                    clip_clr,
  output logic signed [WOUT-1:0]  mix_out,
  output logic                    sample,
  output logic                    busy,
  output logic                    clip,
  output logic                    overrun
);

  localparam int IW   = $clog2(CH);
  localparam int PW   = WIN + GAINW + 1;
  localparam int AW   = PW + $clog2(CH);
  localparam int FRAC = 4;

  localparam logic signed [AW-1:0] OUT_MAX = {{(AW-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
  localparam logic signed [AW-1:0] OUT_MIN = {{(AW-WOUT+1){1'b1}}, {(WOUT-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SAT
  } state_t;

  state_t state, state_next;

  logic        [IW-1:0]    idx;
  logic signed [AW-1:0]    acc;
  logic signed [WIN-1:0]   snap_in   [CH];
  logic        [GAINW-1:0] snap_gain [CH];
  logic        [CH-1:0]    snap_mute;

  logic signed [PW-1:0]    in_ext;
  logic signed [PW-1:0]    gain_ext;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    term;
  logic signed [AW-1:0]    shifted;
  logic                    sat_hi;
  logic                    sat_lo;
  logic signed [WOUT-1:0]  sat_val;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cen) state_next = ACC;
      ACC:     if (idx == IW'(CH - 1)) state_next = SAT;
      SAT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
  always_comb begin
    in_ext   = PW'(snap_in[idx]);
    gain_ext = PW'({1'b0, snap_gain[idx]});
    prod     = in_ext * gain_ext;
    term     = snap_mute[idx] ? '0 : AW'(prod);
  end

  always_comb begin
    shifted = acc >>> FRAC;
    sat_hi  = shifted > OUT_MAX;
    sat_lo  = shifted < OUT_MIN;
    if (sat_hi)      sat_val = {1'b0, {(WOUT-1){1'b1}}};
    else if (sat_lo) sat_val = {1'b1, {(WOUT-1){1'b0}}};
    else             sat_val = shifted[WOUT-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      acc     <= '0;
      mix_out <= '0;
      sample  <= 1'b0;
      busy    <= 1'b0;
      clip    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state  <= state_next;
      sample <= 1'b0;
      // Clear first so that a set event on the same edge wins.
      if (clip_clr) begin
        clip    <= 1'b0;
        overrun <= 1'b0;
      end
      if (cen && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (cen) begin
            acc  <= '0;
            idx  <= '0;
            busy <= 1'b1;
          end
        end
        ACC: begin
          acc <= acc + term;
          idx <= idx + IW'(1);
        end
        SAT: begin
          mix_out <= sat_val;
          sample  <= 1'b1;
          busy    <= 1'b0;
          if (sat_hi || sat_lo) clip <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the snapshot registers carry no reset; they are always rewritten
  // before the accumulator reads them.
  always_ff @(posedge clk) begin
    if (state == IDLE && cen) begin
      for (int i = 0; i < CH; i++) begin
        snap_in[i]   <= ch_in[i*WIN +: WIN];
        snap_gain[i] <= gain[i*GAINW +: GAINW];
      end
      snap_mute <= mute;
    end
  end

endmodule
